// File: rtl/signal_head_driver.sv
// Four-road intersection head driver: right-lane phase sequencer with all-red clearance and
// pedestrian WALK, plus four independent left-turn heads with their own amber timers.
module signal_head_driver #(
    parameter int YELLOW_DURATION  = 3,
    parameter int ALL_RED_DURATION = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_right_lane_signals,
    input  logic       i_left_lane_signals_a,
    input  logic       i_left_lane_signals_b,
    input  logic       i_left_lane_signals_c,
    input  logic       i_left_lane_signals_d,
    output logic [3:0] o_right_red,
    output logic [3:0] o_right_yellow,
    output logic [3:0] o_right_green,
    output logic [3:0] o_left_red,
    output logic [3:0] o_left_yellow,
    output logic [3:0] o_left_green,
    output logic       o_walk,
    output logic [1:0] o_active_road
);

    // state      | meaning
    // S_ALL_RED  | every right head red, clearance timer running
    // S_GREEN    | active_road right head green
    // S_YELLOW   | active_road right head amber, timer running
    // S_WALK     | pedestrian walk, all heads red
    typedef enum logic [1:0] {S_ALL_RED, S_GREEN, S_YELLOW, S_WALK} right_state_t;
    typedef enum logic [1:0] {L_RED, L_GREEN, L_YELLOW} left_state_t;

    localparam logic [7:0] YEL_LAST = 8'(YELLOW_DURATION - 1);
    localparam logic [7:0] AR_LAST  = 8'(ALL_RED_DURATION - 1);

    right_state_t r_state, w_state_nxt;
    logic [7:0]   r_timer, w_timer_nxt;
    logic [1:0]   r_active_road, w_active_road_nxt;

    logic [3:0] w_left_req;
    logic       w_ped_req;
    logic [3:0] w_lred, w_lyellow, w_lgreen;
    logic [3:0] w_road_oh;

    assign w_left_req = {i_left_lane_signals_d, i_left_lane_signals_c,
                         i_left_lane_signals_b, i_left_lane_signals_a};
    assign w_ped_req  = ~|w_left_req;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_ALL_RED;
            r_timer       <= '0;
            r_active_road <= 2'b00;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_active_road <= w_active_road_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_timer_nxt       = r_timer;
        w_active_road_nxt = r_active_road;
        unique case (r_state)
            S_ALL_RED: begin
                // At terminal count with walk pending but a left head still clearing, park here.
                if (r_timer == AR_LAST) begin
                    if (w_ped_req && (&w_lred)) begin
                        w_state_nxt = S_WALK;
                        w_timer_nxt = '0;
                    end else if (!w_ped_req) begin
                        w_state_nxt       = S_GREEN;
                        w_timer_nxt       = '0;
                        w_active_road_nxt = i_right_lane_signals;
                    end
                end else begin
                    w_timer_nxt = r_timer + 8'd1;
                end
            end
            S_GREEN: begin
                if (w_ped_req || (i_right_lane_signals != r_active_road)) begin
                    w_state_nxt = S_YELLOW;
                    w_timer_nxt = '0;
                end
            end
            S_YELLOW: begin
                if (r_timer == YEL_LAST) begin
                    w_state_nxt = S_ALL_RED;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 8'd1;
                end
            end
            S_WALK: begin
                if (!w_ped_req) begin
                    w_state_nxt = S_ALL_RED;
                    w_timer_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_ALL_RED;
                w_timer_nxt = '0;
            end
        endcase
    end

    assign w_road_oh = 4'b0001 << r_active_road;

    always_comb begin
        o_right_red    = 4'hF;
        o_right_yellow = 4'h0;
        o_right_green  = 4'h0;
        o_walk         = 1'b0;
        unique case (r_state)
            S_GREEN: begin
                o_right_green = w_road_oh;
                o_right_red   = ~w_road_oh;
            end
            S_YELLOW: begin
                o_right_yellow = w_road_oh;
                o_right_red    = ~w_road_oh;
            end
            S_WALK:    o_walk = 1'b1;
            default: ;
        endcase
    end

    assign o_active_road = r_active_road;

    for (genvar g = 0; g < 4; g++) begin : g_left
        left_state_t r_lstate, w_lstate_nxt;
        logic [7:0]  r_ltimer, w_ltimer_nxt;

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_lstate <= L_RED;
                r_ltimer <= '0;
            end else begin
                r_lstate <= w_lstate_nxt;
                r_ltimer <= w_ltimer_nxt;
            end
        end

        always_comb begin
            w_lstate_nxt = r_lstate;
            w_ltimer_nxt = r_ltimer;
            unique case (r_lstate)
                L_RED: begin
                    if (w_left_req[g] && (r_state != S_WALK)) w_lstate_nxt = L_GREEN;
                end
                L_GREEN: begin
                    if (!w_left_req[g] || (r_state == S_WALK)) begin
                        w_lstate_nxt = L_YELLOW;
                        w_ltimer_nxt = '0;
                    end
                end
                L_YELLOW: begin
                    if (r_ltimer == YEL_LAST) begin
                        w_lstate_nxt = L_RED;
                        w_ltimer_nxt = '0;
                    end else begin
                        w_ltimer_nxt = r_ltimer + 8'd1;
                    end
                end
                default: begin
                    w_lstate_nxt = L_RED;
                    w_ltimer_nxt = '0;
                end
            endcase
        end

        assign w_lred[g]    = (r_lstate == L_RED);
        assign w_lgreen[g]  = (r_lstate == L_GREEN);
        assign w_lyellow[g] = (r_lstate == L_YELLOW);
    end

    assign o_left_red    = w_lred;
    assign o_left_yellow = w_lyellow;
    assign o_left_green  = w_lgreen;

endmodule
